// File: rtl/hpc_avalon_host.sv
// Avalon-MM master that sequences one full testbench-wrapper run: reset pulse,
// enable, timed run, disable, settle, then read back the three result registers.
`timescale 1ns/1ps
module hpc_avalon_host #(
    parameter int WIDTH         = 32,
    parameter int READ_LATENCY  = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_run_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data_ctr,
    output logic [WIDTH-1:0] o_event_ctr,
    output logic [WIDTH-1:0] o_rand,
    output logic [4:0]       master_address,
    output logic             master_read,
    output logic             master_write,
    output logic [WIDTH-1:0] master_writedata,
    input  logic [WIDTH-1:0] master_readdata,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_RST_ON  = 4'd1,
        WR_RST_OFF = 4'd2,
        WR_EN_ON   = 4'd3,
        RUN        = 4'd4,
        WR_EN_OFF  = 4'd5,
        SETTLE     = 4'd6,
        RD_O1      = 4'd7,
        WAIT_O1    = 4'd8,
        RD_O2      = 4'd9,
        WAIT_O2    = 4'd10,
        RD_O3      = 4'd11,
        WAIT_O3    = 4'd12,
        DONE       = 4'd13
    } state_t;

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] SETTLE_LAST = WIDTH'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [WIDTH-1:0] RD_LAST     = WIDTH'(READ_LATENCY - 1);

    localparam logic [4:0] ADDR_CTRL  = 5'h00;
    localparam logic [4:0] ADDR_EN    = 5'h04;
    localparam logic [4:0] ADDR_DATA  = 5'h08;
    localparam logic [4:0] ADDR_EVENT = 5'h0C;
    localparam logic [4:0] ADDR_RAND  = 5'h10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] run_len_q;

    logic             wr_d, rd_d;
    logic [4:0]       addr_d;
    logic [WIDTH-1:0] wdata_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (i_start) state_d = WR_RST_ON;
            WR_RST_ON:  state_d = WR_RST_OFF;
            WR_RST_OFF: state_d = WR_EN_ON;
            WR_EN_ON:   state_d = (run_len_q == '0) ? WR_EN_OFF : RUN;
            RUN:        if (i_abort || cnt_q == run_len_q - ONE) state_d = WR_EN_OFF;
            WR_EN_OFF:  state_d = (SETTLE_CYCLES == 0) ? RD_O1 : SETTLE;
            SETTLE:     if (cnt_q == SETTLE_LAST) state_d = RD_O1;
            RD_O1:      state_d = WAIT_O1;
            WAIT_O1:    if (cnt_q == RD_LAST) state_d = RD_O2;
            RD_O2:      state_d = WAIT_O2;
            WAIT_O2:    if (cnt_q == RD_LAST) state_d = RD_O3;
            RD_O3:      state_d = WAIT_O3;
            WAIT_O3:    if (cnt_q == RD_LAST) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // One shared counter times RUN, SETTLE and the read waits; it restarts on every state change.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && state_q != IDLE) cnt_d = cnt_q + ONE;
    end

    // Bus outputs are decoded from the next state so the registered command lands in the state's own cycle.
    always_comb begin
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            WR_RST_ON:  begin wr_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = ONE; end
            WR_RST_OFF: begin wr_d = 1'b1; addr_d = ADDR_CTRL; end
            WR_EN_ON:   begin wr_d = 1'b1; addr_d = ADDR_EN;   wdata_d = ONE; end
            WR_EN_OFF:  begin wr_d = 1'b1; addr_d = ADDR_EN;   end
            RD_O1:      begin rd_d = 1'b1; addr_d = ADDR_DATA;  end
            RD_O2:      begin rd_d = 1'b1; addr_d = ADDR_EVENT; end
            RD_O3:      begin rd_d = 1'b1; addr_d = ADDR_RAND;  end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            run_len_q        <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            master_write     <= 1'b0;
            master_read      <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            o_busy           <= (state_d != IDLE);
            o_done           <= (state_d == DONE);
            master_write     <= wr_d;
            master_read      <= rd_d;
            master_address   <= addr_d;
            master_writedata <= wdata_d;
            if (state_q == IDLE && i_start) run_len_q <= i_run_len;
        end
    end

    // Read data is valid in the last wait cycle; results hold until the next run overwrites them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data_ctr  <= '0;
            o_event_ctr <= '0;
            o_rand      <= '0;
        end else if (cnt_q == RD_LAST) begin
            if (state_q == WAIT_O1) o_data_ctr  <= master_readdata;
            if (state_q == WAIT_O2) o_event_ctr <= master_readdata;
            if (state_q == WAIT_O3) o_rand      <= master_readdata;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_hpc_avalon_host.sv
// Directed bench for hpc_avalon_host: default instance plus a READ_LATENCY=3, SETTLE_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_hpc_avalon_host;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] v0 = 32'h0, v1 = 32'h0, v2 = 32'h0;

    // default instance
    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [31:0] len1 = 32'd0;
    logic        busy1, done1, rd1, wr1;
    logic [31:0] data1, event1, rand1, wdata1, rdata1;
    logic [4:0]  addr1;
    logic [3:0]  dbg1;

    // latency-3, no-settle instance
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [31:0] len2 = 32'd0;
    logic        busy2, done2, rd2, wr2;
    logic [31:0] data2, event2, rand2, wdata2, rdata2;
    logic [4:0]  addr2;
    logic [3:0]  dbg2;

    hpc_avalon_host dut1 (
        .clk(clk), .reset(reset), .i_start(start1), .i_abort(abort1), .i_run_len(len1),
        .o_busy(busy1), .o_done(done1), .o_data_ctr(data1), .o_event_ctr(event1), .o_rand(rand1),
        .master_address(addr1), .master_read(rd1), .master_write(wr1),
        .master_writedata(wdata1), .master_readdata(rdata1), .dbg_state(dbg1)
    );

    hpc_avalon_host #(.WIDTH(32), .READ_LATENCY(3), .SETTLE_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .i_start(start2), .i_abort(abort2), .i_run_len(len2),
        .o_busy(busy2), .o_done(done2), .o_data_ctr(data2), .o_event_ctr(event2), .o_rand(rand2),
        .master_address(addr2), .master_read(rd2), .master_write(wr2),
        .master_writedata(wdata2), .master_readdata(rdata2), .dbg_state(dbg2)
    );

    function automatic logic [31:0] lookup(input logic [4:0] a);
        case (a)
            5'h08:   return v0;
            5'h0C:   return v1;
            5'h10:   return v2;
            default: return 32'hBAD0BAD0;
        endcase
    endfunction

    // slave models: data only valid exactly at the read latency
    logic       rv1 = 1'b0;
    logic [4:0] ra1 = 5'd0;
    always @(posedge clk) begin
        rv1 <= rd1;
        ra1 <= addr1;
    end
    assign rdata1 = rv1 ? lookup(ra1) : 32'hDEADBEEF;

    logic [2:0] rv2 = 3'd0;
    logic [4:0] ra2 [3] = '{default: 5'd0};
    always @(posedge clk) begin
        rv2    <= {rv2[1:0], rd2};
        ra2[2] <= ra2[1];
        ra2[1] <= ra2[0];
        ra2[0] <= addr2;
    end
    assign rdata2 = rv2[2] ? lookup(ra2[2]) : 32'hDEADBEEF;

    wire [38:0] bus1 = {wr1, rd1, addr1, wdata1};
    wire [38:0] bus2 = {wr2, rd2, addr2, wdata2};

    // expected {write, read, address, writedata} for cycle c of a sequence started in cycle 0
    function automatic logic [38:0] exp_bus(input int c, input int en_off, input int rd0, input int lat);
        if (c == 1)                return {1'b1, 1'b0, 5'h00, 32'd1};
        if (c == 2)                return {1'b1, 1'b0, 5'h00, 32'd0};
        if (c == 3)                return {1'b1, 1'b0, 5'h04, 32'd1};
        if (c == en_off)           return {1'b1, 1'b0, 5'h04, 32'd0};
        if (c == rd0)              return {1'b0, 1'b1, 5'h08, 32'd0};
        if (c == rd0 + 1 + lat)    return {1'b0, 1'b1, 5'h0C, 32'd0};
        if (c == rd0 + 2*(1+lat))  return {1'b0, 1'b1, 5'h10, 32'd0};
        return 39'd0;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus1 !== 39'd0) begin miscompares++; $display("FAIL reset_bus1 got %h want 0", bus1); end
        vectors++; if ({busy1, done1} !== 2'b00) begin miscompares++; $display("FAIL reset_flags1 got %b want 00", {busy1, done1}); end
        vectors++; if ({data1, event1, rand1} !== 96'd0) begin miscompares++; $display("FAIL reset_results1 got %h want 0", {data1, event1, rand1}); end
        vectors++; if (dbg1 !== 4'd0) begin miscompares++; $display("FAIL reset_state1 got %0d want 0", dbg1); end
        vectors++; if (bus2 !== 39'd0) begin miscompares++; $display("FAIL reset_bus2 got %h want 0", bus2); end
        vectors++; if ({busy2, done2, data2, event2, rand2} !== 98'd0) begin miscompares++; $display("FAIL reset_out2 got %h want 0", {busy2, done2, data2, event2, rand2}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        v0 = a; v1 = b; v2 = d;
        @(negedge clk);
        start1 = 1'b1; len1 = 32'd10;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            vectors++; if (bus1 !== exp_bus(c, 14, 19, 1)) begin miscompares++; $display("FAIL basic_bus c=%0d got %h want %h", c, bus1, exp_bus(c, 14, 19, 1)); end
            vectors++; if (busy1 !== (c <= 25)) begin miscompares++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy1, (c <= 25)); end
            vectors++; if (done1 !== (c == 25)) begin miscompares++; $display("FAIL basic_done c=%0d got %b want %b", c, done1, (c == 25)); end
        end
        vectors++; if ({data1, event1, rand1} !== {a, b, d}) begin miscompares++; $display("FAIL basic_results got %h want %h", {data1, event1, rand1}, {a, b, d}); end
    endtask

    task automatic test_zero_len();
        v0 = 32'h44; v1 = 32'h55; v2 = 32'h66;
        @(negedge clk);
        start1 = 1'b1; abort1 = 1'b1; len1 = 32'd0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin start1 = 1'b0; abort1 = 1'b0; end
            vectors++; if (bus1 !== exp_bus(c, 4, 9, 1)) begin miscompares++; $display("FAIL zero_bus c=%0d got %h want %h", c, bus1, exp_bus(c, 4, 9, 1)); end
            vectors++; if (done1 !== (c == 15)) begin miscompares++; $display("FAIL zero_done c=%0d got %b want %b", c, done1, (c == 15)); end
            if (c == 5) begin
                vectors++; if (data1 !== 32'h11) begin miscompares++; $display("FAIL zero_hold got %h want 11", data1); end
            end
        end
        vectors++; if ({data1, event1, rand1} !== {32'h44, 32'h55, 32'h66}) begin miscompares++; $display("FAIL zero_results got %h want 445566", {data1, event1, rand1}); end
    endtask

    task automatic test_abort();
        v0 = 32'h77; v1 = 32'h88; v2 = 32'h99;
        @(negedge clk);
        start1 = 1'b1; len1 = 32'd100;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            vectors++; if (bus1 !== exp_bus(c, 11, 16, 1)) begin miscompares++; $display("FAIL abort_bus c=%0d got %h want %h", c, bus1, exp_bus(c, 11, 16, 1)); end
            vectors++; if (done1 !== (c == 22)) begin miscompares++; $display("FAIL abort_done c=%0d got %b want %b", c, done1, (c == 22)); end
            abort1 = (c == 10) || (c == 13);
        end
        vectors++; if ({data1, event1, rand1} !== {32'h77, 32'h88, 32'h99}) begin miscompares++; $display("FAIL abort_results got %h want 778899", {data1, event1, rand1}); end
    endtask

    task automatic test_restart();
        v0 = 32'h12; v1 = 32'h34; v2 = 32'h56;
        @(negedge clk);
        start1 = 1'b1; len1 = 32'd10;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            vectors++;
            if (c <= 26) begin
                if (bus1 !== exp_bus(c, 14, 19, 1)) begin miscompares++; $display("FAIL restart_bus c=%0d got %h want %h", c, bus1, exp_bus(c, 14, 19, 1)); end
            end else begin
                if (bus1 !== exp_bus(c - 26, 14, 19, 1)) begin miscompares++; $display("FAIL restart_bus c=%0d got %h want %h", c, bus1, exp_bus(c - 26, 14, 19, 1)); end
            end
            vectors++; if (busy1 !== (c <= 25 || (c >= 27 && c <= 51))) begin miscompares++; $display("FAIL restart_busy c=%0d got %b", c, busy1); end
            vectors++; if (done1 !== (c == 25 || c == 51)) begin miscompares++; $display("FAIL restart_done c=%0d got %b", c, done1); end
            start1 = (c == 5) || (c == 25) || (c == 26);
        end
    endtask

    task automatic test_lat3();
        v0 = 32'hA1; v1 = 32'hB2; v2 = 32'hC3;
        @(negedge clk);
        start2 = 1'b1; len2 = 32'd2;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            vectors++; if (bus2 !== exp_bus(c, 6, 7, 3)) begin miscompares++; $display("FAIL lat3_bus c=%0d got %h want %h", c, bus2, exp_bus(c, 6, 7, 3)); end
            vectors++; if (busy2 !== (c <= 19)) begin miscompares++; $display("FAIL lat3_busy c=%0d got %b", c, busy2); end
            vectors++; if (done2 !== (c == 19)) begin miscompares++; $display("FAIL lat3_done c=%0d got %b", c, done2); end
            if (c == 10) begin
                vectors++; if (data2 !== 32'h0) begin miscompares++; $display("FAIL lat3_early got %h want 0", data2); end
            end
            if (c == 11) begin
                vectors++; if (data2 !== 32'hA1) begin miscompares++; $display("FAIL lat3_capture got %h want a1", data2); end
            end
        end
        vectors++; if ({event2, rand2} !== {32'hB2, 32'hC3}) begin miscompares++; $display("FAIL lat3_results got %h want b2c3", {event2, rand2}); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start1 = 1'b1; len1 = 32'd10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL midrst_busy c=%0d got %b want 1", c, busy1); end
        end
        reset = 1'b0;
        #1;
        vectors++; if (bus1 !== 39'd0) begin miscompares++; $display("FAIL midrst_bus got %h want 0", bus1); end
        vectors++; if ({busy1, done1} !== 2'b00) begin miscompares++; $display("FAIL midrst_flags got %b want 00", {busy1, done1}); end
        vectors++; if ({data1, event1, rand1} !== 96'd0) begin miscompares++; $display("FAIL midrst_results got %h want 0", {data1, event1, rand1}); end
        vectors++; if ({data2, event2, rand2} !== 96'd0) begin miscompares++; $display("FAIL midrst_results2 got %h want 0", {data2, event2, rand2}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if ({busy1, done1, wr1, rd1} !== 4'b0000) begin miscompares++; $display("FAIL midrst_idle c=%0d got %b want 0000", c, {busy1, done1, wr1, rd1}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic(32'h11, 32'h22, 32'h33);
        test_zero_len();
        test_abort();
        test_restart();
        test_lat3();
        test_mid_reset();
        test_basic(32'h5A, 32'h6B, 32'h7C);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hpc_avalon_host.md
Name: hpc_avalon_host

Overview:
- Avalon-MM master that runs one complete hardware test through the testbench wrapper's slave register map.
- On start it performs the fixed sequence: pulse the testbench reset, enable the testbench, run for a programmed number of cycles, disable, settle, then read the data, event and random registers back.
- Sits in the slave's `clk` domain and replaces software-driven register pokes for batch and regression runs.

Parameters:
- WIDTH, 32, data width of the bus and result registers.
- READ_LATENCY, 1, fixed cycles from the read-command cycle to valid `master_readdata`; legal range 1-7.
- SETTLE_CYCLES, 4, idle cycles after the enable is cleared, before the first read; lets `clk_tb`-domain counters stop. 0 is legal.

Ports:
- clk  in  1  bus/sequencer clock.
- reset  in  1  asynchronous reset, active-low.
- i_start  in  1  single-cycle request; sampled only in IDLE.
- i_abort  in  1  ends the RUN phase early; ignored in every other state.
- i_run_len  in  WIDTH  RUN-phase length in clk cycles; latched on the accepted start.
- o_busy  out  1  high from the cycle after an accepted start through DONE inclusive.
- o_done  out  1  one-cycle pulse in DONE.
- o_data_ctr  out  WIDTH  value read from 0x08.
- o_event_ctr  out  WIDTH  value read from 0x0C.
- o_rand  out  WIDTH  value read from 0x10.
- master_address  out  5  register byte address.
- master_read  out  1  read command, one cycle per access.
- master_write  out  1  write command, one cycle per access.
- master_writedata  out  WIDTH  write data.
- master_readdata  in  WIDTH  read data, valid READ_LATENCY cycles after the read cycle.

Behaviour:
- Register map: 0x00 ctrl (bit0 = tb reset), 0x04 enable (bit0), 0x08 data_ctr, 0x0C event_ctr, 0x10 rand.
- No waitrequest: every command is accepted in its own cycle.
- Reset (`reset` low), asynchronous: state IDLE, run counter 0, and every output 0 (`master_*`, `o_busy`, `o_done`, result registers).
- All outputs are registered. `master_read` and `master_write` are never high together and are high for exactly one cycle per access.
- States and actions:
  - IDLE: on `i_start`=1, latch `i_run_len` and go to WR_RST_ON.
  - WR_RST_ON: write 0x00 ← 1.
  - WR_RST_OFF: write 0x00 ← 0.
  - WR_EN_ON: write 0x04 ← 1.
  - RUN: count the latched length. Latched length 0 skips RUN. `i_abort`=1 in any RUN cycle exits next cycle.
  - WR_EN_OFF: write 0x04 ← 0.
  - SETTLE: SETTLE_CYCLES idle cycles; skipped when 0.
  - RD_O1 then WAIT_O1: read 0x08, then wait READ_LATENCY cycles. Capture `master_readdata` into `o_data_ctr` in the last wait cycle.
  - RD_O2 then WAIT_O2: same for 0x0C into `o_event_ctr`.
  - RD_O3 then WAIT_O3: same for 0x10 into `o_rand`.
  - DONE: `o_done`=1, then return to IDLE.
- Timing: with start sampled in cycle 0, `o_done` is high in cycle 3 + N + 1 + SETTLE_CYCLES + 3*(1+READ_LATENCY) + 1.
- `master_address` and `master_writedata` are 0 in non-access cycles.
- Result registers hold their values until overwritten by the next run's captures. They are not cleared on start.
- `i_start` while busy is ignored. Start and abort together in IDLE: the start is accepted and the abort is ignored.
- Run counter is WIDTH bits. A latched length of all-ones runs 2^WIDTH-1 cycles with no wrap.
- Reset asserted mid-sequence: immediate return to IDLE with outputs 0. No write 0x04 ← 0 is issued; software must re-run.

Test Plan:
- Defaults, `i_run_len`=10, slave model returns 0x11, 0x22, 0x33 -> writes (0x00,1), (0x00,0), (0x04,1) in cycles 1-3, (0x04,0) in cycle 14; reads 0x08/0x0C/0x10 in cycles 19/21/23; `o_done` in cycle 25; outputs 0x11/0x22/0x33.
- `i_run_len`=0 -> (0x04,0) in cycle 4, `o_done` in cycle 15.
- `i_run_len`=100, `i_abort` pulsed in cycle 10 -> (0x04,0) in cycle 11, `o_done` in cycle 22.
- `i_start` re-pulsed in cycles 5 and 25 of a 10-cycle run -> single sequence; a new start is accepted only in cycle 26 or later.
- READ_LATENCY=3, SETTLE_CYCLES=0, `i_run_len`=2 -> reads in cycles 7/11/15; captures in cycles 10/14/18; `o_done` in cycle 19.
- `reset` low in cycle 8 of a run -> all outputs 0 asynchronously; `o_done` never asserted; a fresh start after release behaves as in the first scenario.
